// File: rtl/riscv_tlb_mmu.sv
// RISC-V MMU stage: bare pass-through or translation through a fully-associative
// 4 KiB-page TLB that refills from an external page-table walker.

package biu_pkg;
    typedef enum logic [2:0] {
        BYTE  = 3'b000,
        HWORD = 3'b001,
        WORD  = 3'b010,
        DWORD = 3'b011,
        QWORD = 3'b100
    } biu_size_t;
endpackage

module riscv_tlb_mmu
    import biu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int PLEN    = (XLEN == 32) ? 34 : 56,
    parameter int ENTRIES = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             tlb_flush_i,
    input  logic             mode_i,
    input  logic             req_i,
    input  logic [XLEN-1:0]  adr_i,
    input  biu_size_t        size_i,
    input  logic             lock_i,
    input  logic             we_i,
    output logic             req_o,
    output logic [PLEN-1:0]  adr_o,
    output biu_size_t        size_o,
    output logic             lock_o,
    output logic             we_o,
    output logic             pagefault_o,
    output logic             busy_o,
    output logic             ptw_req_o,
    output logic [XLEN-13:0] ptw_vpn_o,
    input  logic             ptw_ack_i,
    input  logic [PLEN-13:0] ptw_ppn_i,
    input  logic             ptw_r_i,
    input  logic             ptw_w_i,
    input  logic             ptw_fault_i
);
    localparam int VPN_W = XLEN - 12;
    localparam int PPN_W = PLEN - 12;
    localparam int IDX_W = $clog2(ENTRIES);

    typedef enum logic [1:0] {IDLE, MISS, ABORT} state_t;

    state_t state_q, state_d;

    logic [ENTRIES-1:0] tlb_vld_q;
    logic [ENTRIES-1:0] tlb_r_q;
    logic [ENTRIES-1:0] tlb_w_q;
    logic [VPN_W-1:0]   tlb_vpn_q [ENTRIES];
    logic [PPN_W-1:0]   tlb_ppn_q [ENTRIES];
    logic [IDX_W-1:0]   rr_q;

    logic [VPN_W-1:0]   miss_vpn_p1;
    logic [11:0]        miss_ofs_p1;
    biu_size_t          miss_size_p1;
    logic               miss_lock_p1;
    logic               miss_we_p1;
    logic               tlb_flushed_p1;

    logic [VPN_W-1:0]   req_vpn;
    logic               hit, hit_r, hit_w;
    logic [PPN_W-1:0]   hit_ppn;
    logic [IDX_W-1:0]   victim;
    logic               use_rr;
    logic               start_miss;
    logic               ack_discard, ack_ok, install;

    function automatic logic permitted(input logic we, input logic r, input logic w);
        return (we & w) | (!we & r);
    endfunction

    // Zero-extends or truncates a virtual address to the physical width.
    function automatic logic [PLEN-1:0] zext_adr(input logic [XLEN-1:0] a);
        logic [PLEN+XLEN-1:0] t;
        t = {{PLEN{1'b0}}, a};
        return t[PLEN-1:0];
    endfunction

    assign req_vpn = adr_i[XLEN-1:12];

    always_comb begin
        hit     = 1'b0;
        hit_r   = 1'b0;
        hit_w   = 1'b0;
        hit_ppn = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (tlb_vld_q[i] && tlb_vpn_q[i] == req_vpn) begin
                hit     = 1'b1;
                hit_r   = tlb_r_q[i];
                hit_w   = tlb_w_q[i];
                hit_ppn = tlb_ppn_q[i];
            end
        end
    end

    // Lowest free slot wins; the round-robin pointer is only consulted when full.
    always_comb begin
        victim = rr_q;
        use_rr = 1'b1;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!tlb_vld_q[i]) begin
                victim = IDX_W'(i);
                use_rr = 1'b0;
            end
        end
    end

    assign start_miss  = !stall_i && req_i && !flush_i && mode_i && !hit;
    assign ack_discard = (state_q == ABORT) || flush_i;
    assign ack_ok      = !ptw_fault_i && permitted(miss_we_p1, ptw_r_i, ptw_w_i);
    assign install     = (state_q == MISS) && ptw_ack_i && !flush_i && ack_ok
                         && !tlb_flush_i && !tlb_flushed_p1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_miss) state_d = MISS;
            MISS: begin
                if (ptw_ack_i)    state_d = IDLE;
                else if (flush_i) state_d = ABORT;
            end
            ABORT:   if (ptw_ack_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    assign busy_o    = (state_q != IDLE);
    assign ptw_req_o = (state_q != IDLE);
    assign ptw_vpn_o = miss_vpn_p1;

    // Stage p1: the missing request is parked here for the duration of the walk.
    always_ff @(posedge clk_i) begin
        if (state_q == IDLE && start_miss) begin
            miss_vpn_p1  <= req_vpn;
            miss_ofs_p1  <= adr_i[11:0];
            miss_size_p1 <= size_i;
            miss_lock_p1 <= lock_i;
            miss_we_p1   <= we_i;
        end
    end

    // An sfence during the walk makes the returning PTE stale for the TLB.
    always_ff @(posedge clk_i) begin
        if (rst_i)                 tlb_flushed_p1 <= 1'b0;
        else if (state_q == IDLE)  tlb_flushed_p1 <= 1'b0;
        else if (tlb_flush_i)      tlb_flushed_p1 <= 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tlb_vld_q <= '0;
            rr_q      <= '0;
        end else if (tlb_flush_i) begin
            tlb_vld_q <= '0;
        end else if (install) begin
            tlb_vld_q[victim] <= 1'b1;
            if (use_rr) rr_q <= rr_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (install) begin
            tlb_vpn_q[victim] <= miss_vpn_p1;
            tlb_ppn_q[victim] <= ptw_ppn_i;
            tlb_r_q[victim]   <= ptw_r_i;
            tlb_w_q[victim]   <= ptw_w_i;
        end
    end

    // Output stage: loads on unstalled IDLE cycles, or unconditionally on walker ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_o       <= 1'b0;
            pagefault_o <= 1'b0;
            adr_o       <= '0;
            size_o      <= BYTE;
            lock_o      <= 1'b0;
            we_o        <= 1'b0;
        end else if (state_q == IDLE) begin
            if (!stall_i) begin
                req_o       <= 1'b0;
                pagefault_o <= 1'b0;
                if (req_i && !flush_i && (!mode_i || hit)) begin
                    size_o <= size_i;
                    lock_o <= lock_i;
                    we_o   <= we_i;
                    if (!mode_i) begin
                        req_o <= 1'b1;
                        adr_o <= zext_adr(adr_i);
                    end else if (permitted(we_i, hit_r, hit_w)) begin
                        req_o <= 1'b1;
                        adr_o <= {hit_ppn, adr_i[11:0]};
                    end else begin
                        pagefault_o <= 1'b1;
                        adr_o       <= zext_adr(adr_i);
                    end
                end
            end
        end else if (ptw_ack_i) begin
            req_o       <= 1'b0;
            pagefault_o <= 1'b0;
            if (!ack_discard) begin
                size_o <= miss_size_p1;
                lock_o <= miss_lock_p1;
                we_o   <= miss_we_p1;
                if (ack_ok) begin
                    req_o <= 1'b1;
                    adr_o <= {ptw_ppn_i, miss_ofs_p1};
                end else begin
                    pagefault_o <= 1'b1;
                    adr_o       <= zext_adr({miss_vpn_p1, miss_ofs_p1});
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_tlb_mmu.sv
// Bench for riscv_tlb_mmu: vector table for single-cycle traffic plus walker
// sequences; every output slot is matched against a queue of expected results.

module tb_riscv_tlb_mmu;
    import biu_pkg::*;

    localparam int XLEN    = 32;
    localparam int PLEN    = 34;
    localparam int ENTRIES = 2;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        stall_i = 1'b0, flush_i = 1'b0, tlb_flush_i = 1'b0, mode_i = 1'b0;
    logic        req_i = 1'b0, lock_i = 1'b0, we_i = 1'b0;
    logic [31:0] adr_i = '0;
    biu_size_t   size_i = BYTE;
    logic        req_o, lock_o, we_o, pagefault_o, busy_o, ptw_req_o;
    logic [33:0] adr_o;
    biu_size_t   size_o;
    logic [19:0] ptw_vpn_o;
    logic        ptw_ack_i = 1'b0, ptw_r_i = 1'b0, ptw_w_i = 1'b0, ptw_fault_i = 1'b0;
    logic [21:0] ptw_ppn_i = '0;

    riscv_tlb_mmu #(.XLEN(XLEN), .PLEN(PLEN), .ENTRIES(ENTRIES)) dut (
        .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
        .tlb_flush_i(tlb_flush_i), .mode_i(mode_i), .req_i(req_i), .adr_i(adr_i),
        .size_i(size_i), .lock_i(lock_i), .we_i(we_i), .req_o(req_o), .adr_o(adr_o),
        .size_o(size_o), .lock_o(lock_o), .we_o(we_o), .pagefault_o(pagefault_o),
        .busy_o(busy_o), .ptw_req_o(ptw_req_o), .ptw_vpn_o(ptw_vpn_o),
        .ptw_ack_i(ptw_ack_i), .ptw_ppn_i(ptw_ppn_i), .ptw_r_i(ptw_r_i),
        .ptw_w_i(ptw_w_i), .ptw_fault_i(ptw_fault_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic        flt;
        logic [33:0] adr;
        logic        we;
        logic        lock;
        biu_size_t   size;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        req;
        logic        mode;
        logic        flush;
        logic [31:0] adr;
        logic        we;
        logic        lock;
        biu_size_t   size;
        logic        ereq;
        logic        eflt;
        logic [33:0] eadr;
    } vec_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, want);
        end
    endtask

    task automatic push_exp(input logic req, input logic flt, input logic [33:0] adr,
                            input logic we, input logic lock, input biu_size_t size);
        exp_t e;
        e.req = req; e.flt = flt; e.adr = adr; e.we = we; e.lock = lock; e.size = size;
        e.cyc = cyc + 1;
        sb_q.push_back(e);
    endtask

    exp_t mon_e;
    logic mon_bad;
    always @(negedge clk) begin
        if (!rst_i) begin
            if (req_o && pagefault_o) begin
                n_tests++;
                n_fail++;
                $display("FAIL req_fault_excl: cyc=%0d req_o=1 pagefault_o=1, required not both", cyc);
            end
            if (req_o || pagefault_o) begin
                n_tests++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: cyc=%0d req_o=%0b pagefault_o=%0b adr_o=0x%0h, required no output",
                             cyc, req_o, pagefault_o, adr_o);
                end else begin
                    mon_e = sb_q.pop_front();
                    mon_bad = (req_o !== mon_e.req) || (pagefault_o !== mon_e.flt) ||
                              (adr_o !== mon_e.adr) || (cyc != mon_e.cyc);
                    if (mon_e.req)
                        mon_bad = mon_bad || (we_o !== mon_e.we) || (lock_o !== mon_e.lock) ||
                                  (size_o !== mon_e.size);
                    if (mon_bad) begin
                        n_fail++;
                        $display("FAIL sb_item: got cyc=%0d req=%0b flt=%0b adr=0x%0h we=%0b lock=%0b size=%0d, required cyc=%0d req=%0b flt=%0b adr=0x%0h we=%0b lock=%0b size=%0d",
                                 cyc, req_o, pagefault_o, adr_o, we_o, lock_o, size_o,
                                 mon_e.cyc, mon_e.req, mon_e.flt, mon_e.adr, mon_e.we, mon_e.lock, mon_e.size);
                    end
                end
            end
        end
    end

    // One translated access; on a miss the walker answers lat cycles after the request.
    task automatic access(input logic [19:0] vpn, input logic [11:0] ofs, input logic we,
                          input logic exp_hit, input logic [21:0] ppn, input logic pr,
                          input logic pw, input logic pf, input int lat);
        logic ok;
        ok = !pf && (we ? pw : pr);
        @(negedge clk);
        req_i = 1'b1; mode_i = 1'b1; adr_i = {vpn, ofs}; we_i = we; lock_i = 1'b0; size_i = WORD;
        if (exp_hit) push_exp(ok, !ok, ok ? {ppn, ofs} : {2'b00, vpn, ofs}, we, 1'b0, WORD);
        @(negedge clk);
        req_i = 1'b0;
        check("busy_after_req", 64'(busy_o), 64'(!exp_hit));
        check("ptw_req_after_req", 64'(ptw_req_o), 64'(!exp_hit));
        if (!exp_hit) begin
            check("ptw_vpn", 64'(ptw_vpn_o), 64'(vpn));
            repeat (lat - 1) @(negedge clk);
            check("ptw_vpn_held", 64'(ptw_vpn_o), 64'(vpn));
            ptw_ack_i = 1'b1; ptw_ppn_i = ppn; ptw_r_i = pr; ptw_w_i = pw; ptw_fault_i = pf;
            push_exp(ok, !ok, ok ? {ppn, ofs} : {2'b00, vpn, ofs}, we, 1'b0, WORD);
            @(negedge clk);
            ptw_ack_i = 1'b0; ptw_fault_i = 1'b0;
            check("busy_after_ack", 64'(busy_o), 64'd0);
        end else if (busy_o) begin
            ptw_ack_i = 1'b1;
            @(negedge clk);
            ptw_ack_i = 1'b0;
        end
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h8000_1234, 1'b1, 1'b0, WORD,  1'b1, 1'b0, 34'h0_8000_1234};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, BYTE,  1'b1, 1'b0, 34'h0_FFFF_FFFF};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, HWORD, 1'b0, 1'b0, 34'h0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b0, WORD,  1'b1, 1'b0, 34'h0_3ABC_D678};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h1234_5ABC, 1'b1, 1'b0, DWORD, 1'b1, 1'b0, 34'h0_3ABC_DABC};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h0004_2010, 1'b1, 1'b0, WORD,  1'b0, 1'b1, 34'h0_0004_2010};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 32'h0004_2FFC, 1'b0, 1'b1, WORD,  1'b1, 1'b0, 34'h0_0077_7FFC};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 32'h1234_5000, 1'b0, 1'b0, WORD,  1'b0, 1'b0, 34'h0};
        tbl[8] = '{1'b1, 1'b1, 1'b1, 32'h1234_5000, 1'b0, 1'b0, WORD,  1'b0, 1'b0, 34'h0};
        tbl[9] = '{1'b1, 1'b0, 1'b0, 32'h1234_5000, 1'b0, 1'b0, HWORD, 1'b1, 1'b0, 34'h0_1234_5000};

        repeat (3) @(negedge clk);
        check("rst_req_o", 64'(req_o), 64'd0);
        check("rst_pagefault_o", 64'(pagefault_o), 64'd0);
        check("rst_busy_o", 64'(busy_o), 64'd0);
        check("rst_ptw_req_o", 64'(ptw_req_o), 64'd0);
        check("rst_adr_o", 64'(adr_o), 64'd0);
        check("rst_size_o", 64'(size_o), 64'd0);
        check("rst_lock_o", 64'(lock_o), 64'd0);
        check("rst_we_o", 64'(we_o), 64'd0);
        rst_i = 1'b0;

        // Install a read/write page and a read-only page, then confirm a 1-cycle hit.
        access(20'h12345, 12'h678, 1'b0, 1'b0, 22'h3ABCD, 1'b1, 1'b1, 1'b0, 3);
        access(20'h12345, 12'h678, 1'b0, 1'b1, 22'h3ABCD, 1'b1, 1'b1, 1'b0, 1);
        access(20'h00042, 12'h010, 1'b0, 1'b0, 22'h00777, 1'b1, 1'b0, 1'b0, 2);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            req_i = tbl[i].req; mode_i = tbl[i].mode; flush_i = tbl[i].flush;
            adr_i = tbl[i].adr; we_i = tbl[i].we; lock_i = tbl[i].lock; size_i = tbl[i].size;
            if (tbl[i].ereq || tbl[i].eflt)
                push_exp(tbl[i].ereq, tbl[i].eflt, tbl[i].eadr, tbl[i].we, tbl[i].lock, tbl[i].size);
        end
        @(negedge clk);
        req_i = 1'b0; flush_i = 1'b0;
        check("busy_after_table", 64'(busy_o), 64'd0);

        // Walker fault and walker permission failure leave nothing installed.
        access(20'h55555, 12'h111, 1'b0, 1'b0, 22'h00009, 1'b1, 1'b1, 1'b1, 2);
        access(20'h55555, 12'h111, 1'b0, 1'b0, 22'h00001, 1'b1, 1'b1, 1'b0, 1);
        access(20'h66666, 12'h200, 1'b1, 1'b0, 22'h00005, 1'b1, 1'b0, 1'b0, 1);
        access(20'h66666, 12'h200, 1'b0, 1'b0, 22'h00005, 1'b1, 1'b0, 1'b0, 1);

        // Flush two cycles into MISS: walk completes in ABORT and is discarded.
        @(negedge clk);
        req_i = 1'b1; mode_i = 1'b1; adr_i = 32'h0ABC_D010; we_i = 1'b0;
        @(negedge clk);
        req_i = 1'b0;
        check("abort_busy_miss", 64'(busy_o), 64'd1);
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("abort_ptw_req", 64'(ptw_req_o), 64'd1);
        repeat (2) @(negedge clk);
        check("abort_ptw_req_held", 64'(ptw_req_o), 64'd1);
        check("abort_ptw_vpn", 64'(ptw_vpn_o), 64'h0ABCD);
        ptw_ack_i = 1'b1; ptw_ppn_i = 22'h00ABC; ptw_r_i = 1'b1; ptw_w_i = 1'b1;
        @(negedge clk);
        ptw_ack_i = 1'b0;
        check("abort_req_o", 64'(req_o), 64'd0);
        check("abort_pagefault_o", 64'(pagefault_o), 64'd0);
        check("abort_busy_idle", 64'(busy_o), 64'd0);
        access(20'h0ABCD, 12'h010, 1'b0, 1'b0, 22'h00ABC, 1'b1, 1'b1, 1'b0, 1);

        // Flush coincident with ack is an abort as well.
        @(negedge clk);
        req_i = 1'b1; mode_i = 1'b1; adr_i = 32'h0F00_D000; we_i = 1'b0;
        @(negedge clk);
        req_i = 1'b0;
        check("flushack_busy", 64'(busy_o), 64'd1);
        @(negedge clk);
        flush_i = 1'b1; ptw_ack_i = 1'b1; ptw_ppn_i = 22'h00003;
        @(negedge clk);
        flush_i = 1'b0; ptw_ack_i = 1'b0;
        check("flushack_req_o", 64'(req_o), 64'd0);
        check("flushack_busy_idle", 64'(busy_o), 64'd0);
        access(20'h0F00D, 12'h000, 1'b0, 1'b0, 22'h00003, 1'b1, 1'b1, 1'b0, 1);

        // sfence during MISS with stall on the ack: result delivered, not installed.
        @(negedge clk);
        req_i = 1'b1; mode_i = 1'b1; adr_i = 32'h0BEE_F024; we_i = 1'b0;
        @(negedge clk);
        req_i = 1'b0; tlb_flush_i = 1'b1;
        check("sfence_busy", 64'(busy_o), 64'd1);
        @(negedge clk);
        tlb_flush_i = 1'b0; stall_i = 1'b1;
        ptw_ack_i = 1'b1; ptw_ppn_i = 22'h00123; ptw_r_i = 1'b1; ptw_w_i = 1'b1;
        push_exp(1'b1, 1'b0, 34'h0_0012_3024, 1'b0, 1'b0, WORD);
        @(negedge clk);
        ptw_ack_i = 1'b0; stall_i = 1'b0;
        access(20'h0BEEF, 12'h024, 1'b0, 1'b0, 22'h00123, 1'b1, 1'b1, 1'b0, 1);

        // Replacement order with two entries, starting from a fresh reset.
        @(negedge clk);
        rst_i = 1'b1;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        access(20'h0000A, 12'h001, 1'b0, 1'b0, 22'h000A1, 1'b1, 1'b1, 1'b0, 1);
        access(20'h0000B, 12'h002, 1'b0, 1'b0, 22'h000B1, 1'b1, 1'b1, 1'b0, 1);
        access(20'h0000C, 12'h003, 1'b0, 1'b0, 22'h000C1, 1'b1, 1'b1, 1'b0, 1);
        access(20'h0000B, 12'h004, 1'b0, 1'b1, 22'h000B1, 1'b1, 1'b1, 1'b0, 1);
        access(20'h0000C, 12'h005, 1'b1, 1'b1, 22'h000C1, 1'b1, 1'b1, 1'b0, 1);
        access(20'h0000A, 12'h006, 1'b0, 1'b0, 22'h000A2, 1'b1, 1'b1, 1'b0, 1);
        access(20'h0000C, 12'h007, 1'b0, 1'b1, 22'h000C1, 1'b1, 1'b1, 1'b0, 1);
        access(20'h0000B, 12'h008, 1'b0, 1'b0, 22'h000B2, 1'b1, 1'b1, 1'b0, 1);
        @(negedge clk);
        tlb_flush_i = 1'b1;
        @(negedge clk);
        tlb_flush_i = 1'b0;
        access(20'h0000A, 12'h009, 1'b0, 1'b0, 22'h000A3, 1'b1, 1'b1, 1'b0, 1);
        access(20'h0000B, 12'h00A, 1'b0, 1'b0, 22'h000B3, 1'b1, 1'b1, 1'b0, 1);
        access(20'h0000C, 12'h00B, 1'b0, 1'b0, 22'h000C3, 1'b1, 1'b1, 1'b0, 1);

        repeat (3) @(negedge clk);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
